// File: rtl/tri_scan_ctrl.sv
// Point-in-triangle scan over a small table; one shared edge evaluator, 3 cycles per valid entry, 1 per invalid, +1 to result.
// Single point in flight: pt_ready/cfg_ready only in IDLE, result held until res_ready.
module tri_scan_ctrl #(
  parameter int COORD_W = 12,
  parameter int MAX_TRI = 4,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic                      cfg_valid,
  input  logic signed [COORD_W-1:0] cfg_v0x,
  input  logic signed [COORD_W-1:0] cfg_v0y,
  input  logic signed [COORD_W-1:0] cfg_v1x,
  input  logic signed [COORD_W-1:0] cfg_v1y,
  input  logic signed [COORD_W-1:0] cfg_v2x,
  input  logic signed [COORD_W-1:0] cfg_v2y,
  output logic                      cfg_ready,
  input  logic                      pt_valid,
  output logic                      pt_ready,
  input  logic signed [COORD_W-1:0] pt_x,
  input  logic signed [COORD_W-1:0] pt_y,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_hit,
  output logic [IDX_W-1:0]          res_idx
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;
  localparam int EW = 2 * COORD_W + 3;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_tri, w_tri_nxt;
  logic [1:0]                r_edge, w_edge_nxt;
  logic                      r_s0, r_s1;
  logic signed [COORD_W-1:0] r_px, r_py;
  logic                      r_res_valid, r_res_hit;
  logic [IDX_W-1:0]          r_res_idx;
  logic [MAX_TRI-1:0]        r_valid;
  logic signed [COORD_W-1:0] r_vx [MAX_TRI][3];
  logic signed [COORD_W-1:0] r_vy [MAX_TRI][3];

  logic                      w_accept, w_cfg_acc, w_last, w_inside, w_done, w_hit;
  logic signed [COORD_W-1:0] w_ax, w_ay, w_bx, w_by;
  logic signed [DW-1:0]      w_d1, w_d2, w_d3, w_d4;
  logic signed [PW-1:0]      w_p1, w_p2;
  logic signed [EW-1:0]      w_e;
  logic                      w_s;

  assign w_accept  = (r_state == IDLE) && pt_valid;
  assign w_cfg_acc = (r_state == IDLE) && cfg_we;
  assign w_last    = (r_tri == IDX_W'(MAX_TRI - 1));

  // Edge k runs from vertex k to vertex k+1 (wrapping), so A/B rotate through the stored triple.
  always_comb begin
    w_ax = r_vx[r_tri][0];
    w_ay = r_vy[r_tri][0];
    w_bx = r_vx[r_tri][1];
    w_by = r_vy[r_tri][1];
    case (r_edge)
      2'd1: begin
        w_ax = r_vx[r_tri][1];
        w_ay = r_vy[r_tri][1];
        w_bx = r_vx[r_tri][2];
        w_by = r_vy[r_tri][2];
      end
      2'd2: begin
        w_ax = r_vx[r_tri][2];
        w_ay = r_vy[r_tri][2];
        w_bx = r_vx[r_tri][0];
        w_by = r_vy[r_tri][0];
      end
      default: ;
    endcase
  end

  assign w_d1 = {r_px[COORD_W-1], r_px} - {w_bx[COORD_W-1], w_bx};
  assign w_d2 = {w_ay[COORD_W-1], w_ay} - {w_by[COORD_W-1], w_by};
  assign w_d3 = {w_ax[COORD_W-1], w_ax} - {w_bx[COORD_W-1], w_bx};
  assign w_d4 = {r_py[COORD_W-1], r_py} - {w_by[COORD_W-1], w_by};
  assign w_p1 = PW'(w_d1) * PW'(w_d2);
  assign w_p2 = PW'(w_d3) * PW'(w_d4);
  assign w_e  = EW'(w_p1) - EW'(w_p2);
  assign w_s  = (w_e >= $signed(EW'(0)));

  assign w_inside = (r_s0 == r_s1) && (r_s1 == w_s);

  always_comb begin
    w_state_nxt = r_state;
    w_tri_nxt   = r_tri;
    w_edge_nxt  = r_edge;
    w_done      = 1'b0;
    w_hit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (pt_valid) begin
          w_state_nxt = EVAL;
          w_tri_nxt   = '0;
          w_edge_nxt  = 2'd0;
        end
      end
      EVAL: begin
        if (!r_valid[r_tri] || r_edge == 2'd2) begin
          if (r_valid[r_tri] && w_inside) begin
            w_done = 1'b1;
            w_hit  = 1'b1;
          end else if (w_last) begin
            w_done = 1'b1;
          end else begin
            w_tri_nxt  = r_tri + IDX_W'(1);
            w_edge_nxt = 2'd0;
          end
        end else begin
          w_edge_nxt = r_edge + 2'd1;
        end
        if (w_done) w_state_nxt = RESP;
      end
      RESP: begin
        if (r_res_valid && res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tri       <= '0;
      r_edge      <= 2'd0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_idx   <= '0;
      r_valid     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tri   <= w_tri_nxt;
      r_edge  <= w_edge_nxt;
      if (w_accept) begin
        r_px <= pt_x;
        r_py <= pt_y;
      end
      if (r_state == EVAL && r_valid[r_tri] && r_edge == 2'd0) r_s0 <= w_s;
      if (r_state == EVAL && r_valid[r_tri] && r_edge == 2'd1) r_s1 <= w_s;
      if (w_done) begin
        r_res_hit <= w_hit;
        r_res_idx <= w_hit ? r_tri : '0;
      end
      // Result register adds one cycle between the final decision and res_valid.
      if (r_state == RESP && !r_res_valid) r_res_valid <= 1'b1;
      else if (r_res_valid && res_ready)   r_res_valid <= 1'b0;
      if (w_cfg_acc) r_valid[cfg_idx] <= cfg_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cfg_acc) begin
      r_vx[cfg_idx][0] <= cfg_v0x;
      r_vy[cfg_idx][0] <= cfg_v0y;
      r_vx[cfg_idx][1] <= cfg_v1x;
      r_vy[cfg_idx][1] <= cfg_v1y;
      r_vx[cfg_idx][2] <= cfg_v2x;
      r_vy[cfg_idx][2] <= cfg_v2y;
    end
  end

  assign cfg_ready = (r_state == IDLE);
  assign pt_ready  = (r_state == IDLE);
  assign res_valid = r_res_valid;
  assign res_hit   = r_res_hit;
  assign res_idx   = r_res_idx;

endmodule

// File: tb/tb_tri_scan_ctrl.sv
// Self-checking bench for tri_scan_ctrl: table of query vectors with hand-derived results, scoreboard queue, corner sequences.
module tb_tri_scan_ctrl;
  localparam int CW = 12;
  localparam int MT = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic cfg_we, cfg_valid, cfg_ready;
  logic [IW-1:0] cfg_idx;
  logic signed [CW-1:0] cfg_v0x, cfg_v0y, cfg_v1x, cfg_v1y, cfg_v2x, cfg_v2y;
  logic pt_valid, pt_ready;
  logic signed [CW-1:0] pt_x, pt_y;
  logic res_valid, res_ready, res_hit;
  logic [IW-1:0] res_idx;

  always #5 clk = ~clk;

  tri_scan_ctrl #(.COORD_W(CW), .MAX_TRI(MT), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
    .cfg_v0x(cfg_v0x), .cfg_v0y(cfg_v0y), .cfg_v1x(cfg_v1x),
    .cfg_v1y(cfg_v1y), .cfg_v2x(cfg_v2x), .cfg_v2y(cfg_v2y),
    .cfg_ready(cfg_ready),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_idx(res_idx)
  );

  typedef struct {
    int px;
    int py;
    int hit;
    int idx;
    int lat;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[7];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int idx, input int v, input int x0, input int y0,
                         input int x1, input int y1, input int x2, input int y2);
    cfg_idx   = IW'(idx);
    cfg_valid = v[0];
    cfg_v0x = CW'(x0); cfg_v0y = CW'(y0);
    cfg_v1x = CW'(x1); cfg_v1y = CW'(y1);
    cfg_v2x = CW'(x2); cfg_v2y = CW'(y2);
  endtask

  task automatic cfg_write(input int idx, input int v, input int x0, input int y0,
                           input int x1, input int y1, input int x2, input int y2);
    check("cfg_ready_idle", int'(cfg_ready), 1);
    set_cfg(idx, v, x0, y0, x1, y1, x2, y2);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Drives one query; any cfg_we already set up is presented on the same accept edge.
  task automatic run_query(input vec_t v, input int hold);
    vec_t e;
    int cnt;
    int w;
    sb_q.push_back(v);
    res_ready = (hold == 0);
    pt_x = CW'(v.px);
    pt_y = CW'(v.py);
    pt_valid = 1'b1;
    w = 0;
    while (!pt_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("pt_ready_before_accept", int'(pt_ready), 1);
    @(posedge clk); #1;
    pt_valid = 1'b0;
    cfg_we = 1'b0;
    check("pt_ready_busy", int'(pt_ready), 0);
    cnt = 0;
    while (!res_valid && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    e = sb_q.pop_front();
    check($sformatf("latency(%0d,%0d)", e.px, e.py), cnt, e.lat);
    check($sformatf("res_hit(%0d,%0d)", e.px, e.py), int'(res_hit), e.hit);
    check($sformatf("res_idx(%0d,%0d)", e.px, e.py), int'(res_idx), e.idx);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        set_cfg(1, 0, 0, 0, 0, 0, 0, 0);
        cfg_we = 1'b1;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      check("hold_res_valid", int'(res_valid), 1);
      check("hold_res_hit", int'(res_hit), e.hit);
      check("hold_res_idx", int'(res_idx), e.idx);
      check("hold_pt_ready", int'(pt_ready), 0);
      check("hold_cfg_ready", int'(cfg_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("res_valid_drop", int'(res_valid), 0);
    check("pt_ready_after", int'(pt_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 1, 0, 4};
    tbl[1] = '{15, 5, 1, 1, 7};
    tbl[2] = '{-3, 3, 0, 0, 11};
    tbl[3] = '{-100, -100, 1, 0, 4};
    tbl[4] = '{0, 0, 0, 0, 11};
    tbl[5] = '{5, 5, 0, 0, 5};
    tbl[6] = '{0, 0, 1, 2, 6};

    rst = 1'b1;
    cfg_we = 1'b0;
    pt_valid = 1'b0;
    res_ready = 1'b1;
    pt_x = '0;
    pt_y = '0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_pt_ready", int'(pt_ready), 1);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_hit", int'(res_hit), 0);
    check("rst_res_idx", int'(res_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    cfg_write(0, 1, -6, -1, 3, 3, 3, -3);
    cfg_write(1, 1, 20, -2, -1, 8, 20, 12);
    cfg_write(2, 1, -17, -4, 5, 15, -43, 20);
    cfg_write(3, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) run_query(tbl[i], 0);

    // Full-range triangle exercises the widest products.
    cfg_write(0, 1, -2048, -2048, 2047, -2048, -2048, 2047);
    for (int i = 3; i < 5; i++) run_query(tbl[i], 0);

    // Attempted invalidation of entry 1 while the result is held must be ignored.
    run_query(tbl[3], 5);
    run_query(tbl[1], 0);

    pt_x = '0;
    pt_y = '0;
    pt_valid = 1'b1;
    @(posedge clk); #1;
    pt_valid = 1'b0;
    @(posedge clk); #1;
    check("eval_before_rst", int'(pt_ready), 0);
    rst = 1'b1;
    #1;
    check("async_rst_pt_ready", int'(pt_ready), 1);
    check("async_rst_res_valid", int'(res_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_res_valid", int'(res_valid), 0);
      check("post_rst_pt_ready", int'(pt_ready), 1);
    end
    run_query(tbl[5], 0);

    // Entry write and point accept on the same edge: scan sees the new entry.
    set_cfg(2, 1, -6, -1, 3, 3, 3, -3);
    cfg_we = 1'b1;
    run_query(tbl[6], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
